// File: rtl/timer_control_pkg.sv
// Shared state encodings and terminal-count constants for the timer control path.
package timer_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_PAUSE = 3'b010,
        ST_DONE  = 3'b011
    } state_t;

    localparam logic [15:0] TERM_UP = 16'h9999;
    localparam logic [15:0] TERM_DN = 16'h0000;

    // digits packed thousands..ones; down selects the count-down terminal
    function automatic logic is_terminal(input logic down, input logic [15:0] digits);
        return digits == (down ? TERM_DN : TERM_UP);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Purpose: synchronize and debounce one raw push-button, emit a one-cycle press pulse.
// Latency: press_p high in the cycle after edge E+1+DB_CYCLES for an input rising before edge E.
// Backpressure: none; free-running, a press is never held off or queued.
module btn_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_p
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press_p <= 1'b0;
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            press_p <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // accept the new level; only a rising acceptance is a press
                level   <= sync2;
                cnt     <= '0;
                press_p <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/timer_control.sv
// Purpose: button conditioning, run/pause/done life-cycle and terminal detect driving time_count.
// Latency: state registered, changes one edge after a press pulse, terminal or mode change.
// Backpressure: none; presses arriving in states that ignore them are dropped.
module timer_control #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic [1:0] m,
    input  logic [3:0] time0,
    input  logic [3:0] time1,
    input  logic [3:0] time2,
    input  logic [3:0] time3,
    output logic [2:0] state,
    output logic       run_led,
    output logic       done_led
);

    import timer_control_pkg::*;

    logic       ss_p;
    logic       clr_p;
    logic [1:0] m_q;
    logic       mode_chg;
    logic       terminal;
    state_t     state_q;
    state_t     state_nxt;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_ss (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_ss),
        .press_p (ss_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_clr),
        .press_p (clr_p)
    );

    assign mode_chg = (m != m_q);
    assign terminal = (state_q == ST_RUN) && is_terminal(m[1], {time3, time2, time1, time0});

    // priority: mode change, clear, terminal, start/stop
    always_comb begin
        state_nxt = state_q;
        if (mode_chg) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!clr_p && ss_p) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (clr_p)         state_nxt = ST_IDLE;
                    else if (terminal) state_nxt = ST_DONE;
                    else if (ss_p)     state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (clr_p)     state_nxt = ST_IDLE;
                    else if (ss_p) state_nxt = ST_RUN;
                end
                ST_DONE:  if (clr_p || ss_p) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // LEDs registered alongside the state so they track it with no extra delay
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            run_led  <= 1'b0;
            done_led <= 1'b0;
            m_q      <= m;
        end else begin
            state_q  <= state_nxt;
            run_led  <= (state_nxt == ST_RUN);
            done_led <= (state_nxt == ST_DONE);
            m_q      <= m;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control: directed scenarios with literal expectations plus randomized traffic vs a reference model.
module tb_timer_control;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic [1:0] m = 2'b00;
    logic [3:0] time0 = 4'd4;
    logic [3:0] time1 = 4'd3;
    logic [3:0] time2 = 4'd2;
    logic [3:0] time3 = 4'd1;
    logic [2:0] state;
    logic       run_led;
    logic       done_led;

    int n_cmp = 0;
    int n_bad = 0;

    timer_control #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_ss   (btn_ss),
        .btn_clr  (btn_clr),
        .m        (m),
        .time0    (time0),
        .time1    (time1),
        .time2    (time2),
        .time3    (time3),
        .state    (state),
        .run_led  (run_led),
        .done_led (done_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [15:0] d);
        {time3, time2, time1, time0} = d;
    endtask

    // hold buttons long enough to be accepted, then release and let the levels drop
    task automatic press(input logic ss, input logic clr);
        btn_ss  = ss;
        btn_clr = clr;
        repeat (7) tick();
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        repeat (8) tick();
    endtask

    // ---------------- reference model ----------------
    // A button press is accepted when the raw input, seen two edges late,
    // has disagreed with the accepted level for DB consecutive samples.
    bit         mdl_valid = 1'b0;
    int         mdl_state = 0;
    bit         lvl [2];
    bit         pls [2];
    bit         hist [2][DB+1];
    bit         raw [2];
    logic [1:0] m_prev;
    bit         all_diff;
    bit         mchg;
    bit         term;
    int         nxt;

    always @(posedge clk) begin
        raw[0] = btn_ss;
        raw[1] = btn_clr;
        if (rst) begin
            mdl_valid = 1'b1;
            mdl_state = 0;
            m_prev    = m;
            for (int b = 0; b < 2; b++) begin
                lvl[b] = 1'b0;
                pls[b] = 1'b0;
                for (int i = 0; i <= DB; i++) hist[b][i] = 1'b0;
            end
        end else begin
            mchg = (m != m_prev);
            term = m[1] ? ({time3, time2, time1, time0} == 16'h0000)
                        : ({time3, time2, time1, time0} == 16'h9999);
            nxt = mdl_state;
            if (mchg) nxt = 0;
            else if (mdl_state == 0) nxt = (!pls[1] && pls[0]) ? 1 : 0;
            else if (mdl_state == 1) nxt = pls[1] ? 0 : term ? 3 : pls[0] ? 2 : 1;
            else if (mdl_state == 2) nxt = pls[1] ? 0 : pls[0] ? 1 : 2;
            else if (mdl_state == 3) nxt = (pls[0] || pls[1]) ? 0 : 3;
            else nxt = 0;
            mdl_state = nxt;
            m_prev    = m;
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= DB; i++) if (hist[b][i] == lvl[b]) all_diff = 1'b0;
                pls[b] = 1'b0;
                if (all_diff) begin
                    lvl[b] = ~lvl[b];
                    pls[b] = lvl[b];
                end
                for (int i = DB; i >= 1; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            chk("state", int'(state), mdl_state);
            chk("run_led", int'(run_led), int'(mdl_state == 1));
            chk("done_led", int'(done_led), int'(mdl_state == 3));
        end
    end

    // ---------------- stimulus ----------------
    int ss_left;
    int clr_left;

    initial begin
        // reset with start/stop held
        rst = 1'b1;
        btn_ss = 1'b1;
        repeat (3) tick();
        chk("rst_state", int'(state), 0);
        chk("rst_run_led", int'(run_led), 0);
        chk("rst_done_led", int'(done_led), 0);
        rst = 1'b0;
        btn_ss = 1'b0;
        tick();
        chk("post_rst_state", int'(state), 0);
        repeat (10) tick();
        chk("post_rst_no_press", int'(state), 0);

        // two-sample glitch is rejected
        btn_ss = 1'b1;
        repeat (2) tick();
        btn_ss = 1'b0;
        repeat (12) tick();
        chk("glitch_state", int'(state), 0);
        chk("glitch_run_led", int'(run_led), 0);

        // press latency: first sampled at edge E, state moves at E+DB+2
        btn_ss = 1'b1;
        for (int k = 0; k < DB + 2; k++) begin
            tick();
            chk("lat_before", int'(state), 0);
        end
        tick();
        chk("lat_run", int'(state), 1);
        chk("lat_run_led", int'(run_led), 1);
        btn_ss = 1'b0;
        repeat (8) tick();

        // count-up terminal
        set_digits(16'h9999);
        tick();
        chk("up_term_state", int'(state), 3);
        chk("up_term_led", int'(done_led), 1);
        press(1'b1, 1'b0);
        chk("done_ss_idle", int'(state), 0);

        // count-down from a 0000 load: one RUN cycle then DONE
        set_digits(16'h0000);
        m = 2'b10;
        repeat (3) tick();
        chk("dn_idle", int'(state), 0);
        btn_ss = 1'b1;
        repeat (DB + 2) tick();
        chk("dn_before", int'(state), 0);
        tick();
        chk("dn_run1", int'(state), 1);
        tick();
        chk("dn_done", int'(state), 3);
        btn_ss = 1'b0;
        repeat (8) tick();

        // zeros are not terminal when counting up
        m = 2'b00;
        repeat (3) tick();
        chk("mode_to_idle", int'(state), 0);
        press(1'b1, 1'b0);
        chk("up_zero_run", int'(state), 1);
        repeat (5) tick();
        chk("up_zero_still_run", int'(state), 1);
        press(1'b1, 1'b0);
        chk("run_to_pause", int'(state), 2);
        press(1'b1, 1'b1);
        chk("clr_wins", int'(state), 0);

        // mode change while paused
        m = 2'b01;
        repeat (3) tick();
        press(1'b1, 1'b0);
        chk("m01_run", int'(state), 1);
        press(1'b1, 1'b0);
        chk("m01_pause", int'(state), 2);
        m = 2'b11;
        tick();
        chk("mode_pause_idle", int'(state), 0);
        chk("mode_pause_led", int'(run_led), 0);

        // randomized traffic, checked every cycle by the model
        ss_left = 0;
        clr_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            if (ss_left == 0) begin
                btn_ss  = 1'($urandom_range(0, 1));
                ss_left = $urandom_range(1, 12);
            end else begin
                ss_left--;
            end
            if (clr_left == 0) begin
                btn_clr  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                clr_left = $urandom_range(1, 12);
            end else begin
                clr_left--;
            end
            if ($urandom_range(0, 59) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       set_digits(16'h9999);
                    1:       set_digits(16'h0000);
                    default: {time3, time2, time1, time0} = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                endcase
            end
            tick();
        end
        rst = 1'b0;
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
